// File: rtl/odyssey_video_gen.sv
// Odyssey-style raster generator: h/v counters, sync and blank timing, and
// spot/wall luma rendered from object positions latched once per frame.
module odyssey_video_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FRONT  = 24,
    parameter int H_SYNC   = 94,
    parameter int H_BACK   = 128,
    parameter int V_ACTIVE = 240,
    parameter int V_FRONT  = 3,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 16,
    parameter int SPOT_W   = 4,
    parameter int SPOT_H   = 8,
    parameter int WALL_X   = 128
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] p1_x,
    input  logic [7:0] p1_y,
    input  logic [7:0] p2_x,
    input  logic [7:0] p2_y,
    input  logic [7:0] ball_x,
    input  logic [7:0] ball_y,
    input  logic       wall_en,
    output logic       HSync,
    output logic       VSync,
    output logic       HBlank,
    output logic       VBlank,
    output logic [7:0] video,
    output logic       frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_BLANK_BEG = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [8:0] V_LAST      = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_BLANK_BEG = 9'(V_ACTIVE);
    localparam logic [8:0] V_CAPTURE   = 9'(V_ACTIVE - 1);
    localparam logic [8:0] V_SYNC_BEG  = 9'(V_ACTIVE + V_FRONT);
    localparam logic [8:0] V_SYNC_END  = 9'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic [8:0] SPOT_W9 = 9'(SPOT_W);
    localparam logic [8:0] SPOT_H9 = 9'(SPOT_H);
    localparam logic [7:0] WALL_U  = 8'(WALL_X);

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } pos_t;

    logic [10:0] h;
    logic [8:0]  v;
    logic        h_wrap;
    logic        v_wrap;
    logic        capture;

    pos_t p1_q;
    pos_t p2_q;
    pos_t ball_q;
    logic wall_q;

    assign h_wrap  = (h == H_LAST);
    assign v_wrap  = (v == V_LAST);
    assign capture = h_wrap && (v == V_CAPTURE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else begin
            // NOTE: state uses <= so every flop samples pre-edge values regardless of block order.
            h <= h_wrap ? 11'd0 : h + 11'd1;
            if (h_wrap) begin
                v <= v_wrap ? 9'd0 : v + 9'd1;
            end
        end
    end

    // Positions change only at vblank start so a frame is never drawn torn.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_q   <= '0;
            p2_q   <= '0;
            ball_q <= '0;
            wall_q <= 1'b0;
        end else if (capture) begin
            p1_q   <= '{x: p1_x,   y: p1_y};
            p2_q   <= '{x: p2_x,   y: p2_y};
            ball_q <= '{x: ball_x, y: ball_y};
            wall_q <= wall_en;
        end
    end

    // 9-bit differences: a position past the beam underflows to >= 257, so no wrap-around hit.
    function automatic logic spot_hit(input logic [7:0] u_pos, input logic [8:0] line,
                                      input pos_t p);
        logic [8:0] du;
        logic [8:0] dv;
        du = {1'b0, u_pos} - {1'b0, p.x};
        dv = line - {1'b0, p.y};
        return (du < SPOT_W9) && (dv < SPOT_H9);
    endfunction

    logic [7:0] u;
    logic       hs_d;
    logic       vs_d;
    logic       hb_d;
    logic       vb_d;
    logic       frame_d;
    logic       any_spot;
    logic       wall_hit;
    logic [7:0] video_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        video_d  = 8'h00;
        u        = h[9:2];
        hb_d     = (h >= H_BLANK_BEG);
        vb_d     = (v >= V_BLANK_BEG);
        hs_d     = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
        vs_d     = (v >= V_SYNC_BEG) && (v < V_SYNC_END);
        frame_d  = (h == 11'd0) && (v == V_BLANK_BEG);
        any_spot = spot_hit(u, v, p1_q) || spot_hit(u, v, p2_q) || spot_hit(u, v, ball_q);
        wall_hit = wall_q && (u == WALL_U);
        if (!hb_d && !vb_d) begin
            if (any_spot) begin
                video_d = 8'hFF;
            end else if (wall_hit) begin
                video_d = 8'hC0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HSync  <= 1'b0;
            VSync  <= 1'b0;
            HBlank <= 1'b1;
            VBlank <= 1'b1;
            frame  <= 1'b0;
            video  <= 8'h00;
        end else begin
            HSync  <= hs_d;
            VSync  <= vs_d;
            HBlank <= hb_d;
            VBlank <= vb_d;
            frame  <= frame_d;
            video  <= video_d;
        end
    end

endmodule

// File: tb/tb_odyssey_video_gen.sv
// Bench for odyssey_video_gen: full-width lines, shortened frame height,
// every output compared each clock against a raster model built from arithmetic.
module tb_odyssey_video_gen;

    localparam int HA = 1024, HF = 24, HS = 94, HB = 128;
    localparam int HT = HA + HF + HS + HB;
    localparam int VA = 16, VF = 2, VS = 2, VB = 2;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int SW = 4, SH = 8, WX = 128;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
        logic       fr;
        logic [7:0] vid;
    } out_t;

    localparam out_t RESET_O = '{hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1, fr: 1'b0, vid: 8'h00};

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] p1_x = 8'd0, p1_y = 8'd0, p2_x = 8'd0, p2_y = 8'd0;
    logic [7:0] ball_x = 8'd0, ball_y = 8'd0;
    logic       wall_en = 1'b0;
    logic       HSync, VSync, HBlank, VBlank, frame;
    logic [7:0] video;

    always #5 clk = ~clk;

    odyssey_video_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SPOT_W(SW), .SPOT_H(SH), .WALL_X(WX)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .ball_x(ball_x), .ball_y(ball_y), .wall_en(wall_en),
        .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .video(video), .frame(frame)
    );

    out_t got_o;
    assign got_o = {HSync, VSync, HBlank, VBlank, frame, video};

    int   errors = 0;
    int   checks = 0;
    int   s = 0;
    int   edge_n = 0;
    int   sh_x[3];
    int   sh_y[3];
    bit   sh_wall = 1'b0;
    out_t exp_o;
    int   frame_q[$];
    int   vs_cnt[4];
    int   vb_cnt[4];

    // Expected outputs after the edge leaving raster state st (cycles since reset release).
    function automatic out_t model(int st);
        out_t o;
        int   h, v, u;
        bit   hit;
        h = st % HT;
        v = (st / HT) % VT;
        o.hs = (h >= HA + HF) && (h < HA + HF + HS);
        o.vs = (v >= VA + VF) && (v < VA + VF + VS);
        o.hb = (h >= HA);
        o.vb = (v >= VA);
        o.fr = (h == 0) && (v == VA);
        o.vid = 8'h00;
        if (!o.hb && !o.vb) begin
            u = (h / 4) % 256;
            hit = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (u >= sh_x[k] && u < sh_x[k] + SW && v >= sh_y[k] && v < sh_y[k] + SH)
                    hit = 1'b1;
            end
            if (hit) o.vid = 8'hFF;
            else if (sh_wall && u == WX) o.vid = 8'hC0;
        end
        return o;
    endfunction

    task automatic model_reset();
        s = 0;
        edge_n = 0;
        sh_wall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sh_x[k] = 0;
            sh_y[k] = 0;
        end
        exp_o = RESET_O;
    endtask

    task automatic tick();
        int fi;
        @(posedge clk);
        exp_o = model(s);
        if (s % FT == HT * VA - 1) begin
            sh_x[0] = int'(p1_x);   sh_y[0] = int'(p1_y);
            sh_x[1] = int'(p2_x);   sh_y[1] = int'(p2_y);
            sh_x[2] = int'(ball_x); sh_y[2] = int'(ball_y);
            sh_wall = wall_en;
        end
        s++;
        edge_n++;
        @(negedge clk);
        if (frame === 1'b1) frame_q.push_back(edge_n);
        fi = (s - 1) / FT;
        if (fi < 4) begin
            vs_cnt[fi] += int'(VSync);
            vb_cnt[fi] += int'(VBlank);
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (got_o !== RESET_O) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", got_o, RESET_O);
        end
    endtask

    task automatic test_line_timing();
        int  first = -1, second = -1, width = 0, hb1 = 0;
        logic prev = 1'b0;
        p1_x = 8'd10;  p1_y = 8'd2;
        p2_x = 8'd0;   p2_y = 8'd250;
        ball_x = 8'd0; ball_y = 8'd250;
        wall_en = 1'b0;
        reset_n = 1'b1;
        for (int n = 0; n < 2 * HT; n++) begin
            tick();
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL line_timing edge %0d: got %h expected %h", edge_n, got_o, exp_o);
            end
            if (HSync === 1'b1 && prev !== 1'b1) begin
                if (first < 0) first = edge_n;
                else if (second < 0) second = edge_n;
            end
            prev = HSync;
            if (edge_n <= HT && HSync === 1'b1) width++;
            if (edge_n <= HT && HBlank === 1'b1) hb1++;
        end
        checks++;
        if (first != 1049) begin
            errors++; $display("FAIL hsync_first_edge: got %0d expected 1049", first);
        end
        checks++;
        if (width != 94) begin
            errors++; $display("FAIL hsync_width: got %0d expected 94", width);
        end
        checks++;
        if (second - first != 1270) begin
            errors++; $display("FAIL hsync_period: got %0d expected 1270", second - first);
        end
        checks++;
        if (hb1 != 246) begin
            errors++; $display("FAIL hblank_per_line: got %0d expected 246", hb1);
        end
    endtask

    // Frame 1 shows p1 latched at end of frame 0; mid-frame input changes must not leak in.
    task automatic test_spot_and_shadow();
        int ff1 = 0, ff_out = 0;
        int st, h, v;
        while (s < 2 * FT) begin
            tick();
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL spot_shadow edge %0d: got %h expected %h", edge_n, got_o, exp_o);
            end
            st = s - 1;
            h = st % HT;
            v = (st / HT) % VT;
            if (st / FT == 1 && video === 8'hFF) begin
                ff1++;
                if (h < 40 || h > 55 || v < 2 || v > 9) ff_out++;
            end
            if (s == FT + 8 * HT) begin
                p1_x = 8'd100;
                p2_x = 8'd127;  p2_y = 8'd4;
                ball_x = 8'd254; ball_y = 8'd12;
                wall_en = 1'b1;
            end
            if (s == FT + HT * VA) begin
                ball_x = 8'd0;
                p1_y = 8'd0;
            end
        end
        checks++;
        if (ff1 != 128) begin
            errors++; $display("FAIL p1_spot_pixels: got %0d expected 128", ff1);
        end
        checks++;
        if (ff_out != 0) begin
            errors++; $display("FAIL p1_spot_outside: got %0d expected 0", ff_out);
        end
    endtask

    task automatic test_edges_and_wall();
        int ball_ff = 0, left_ff = 0, wall_c0 = 0, wall_out = 0, p2_ff = 0;
        int st, h;
        while (s < 3 * FT) begin
            tick();
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL edges_wall edge %0d: got %h expected %h", edge_n, got_o, exp_o);
            end
            st = s - 1;
            h = st % HT;
            if (video === 8'hFF && h >= 1016) ball_ff++;
            if (video === 8'hFF && h < 8) left_ff++;
            if (video === 8'hFF && h >= 508 && h <= 523) p2_ff++;
            if (video === 8'hC0) begin
                wall_c0++;
                if (h < 512 || h > 515) wall_out++;
            end
        end
        checks++;
        if (ball_ff != 32) begin
            errors++; $display("FAIL ball_clipped_pixels: got %0d expected 32", ball_ff);
        end
        checks++;
        if (left_ff != 0) begin
            errors++; $display("FAIL ball_wrap_left: got %0d expected 0", left_ff);
        end
        checks++;
        if (p2_ff != 128) begin
            errors++; $display("FAIL p2_over_wall: got %0d expected 128", p2_ff);
        end
        checks++;
        if (wall_c0 != 32) begin
            errors++; $display("FAIL wall_pixels: got %0d expected 32", wall_c0);
        end
        checks++;
        if (wall_out != 0) begin
            errors++; $display("FAIL wall_position: got %0d expected 0", wall_out);
        end
    endtask

    task automatic test_frame_timing();
        checks++;
        if (frame_q.size() != 3) begin
            errors++; $display("FAIL frame_pulse_count: got %0d expected 3", frame_q.size());
        end else begin
            checks++;
            if (frame_q[0] != HT * VA + 1) begin
                errors++; $display("FAIL frame_first_edge: got %0d expected %0d", frame_q[0], HT * VA + 1);
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (frame_q[k] - frame_q[k-1] != FT) begin
                    errors++;
                    $display("FAIL frame_period: got %0d expected %0d", frame_q[k] - frame_q[k-1], FT);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (vs_cnt[k] != VS * HT) begin
                errors++; $display("FAIL vsync_clocks f%0d: got %0d expected %0d", k, vs_cnt[k], VS * HT);
            end
            checks++;
            if (vb_cnt[k] != (VT - VA) * HT) begin
                errors++; $display("FAIL vblank_clocks f%0d: got %0d expected %0d", k, vb_cnt[k], (VT - VA) * HT);
            end
        end
    endtask

    task automatic test_reset_midline();
        int   first = -1, pulses = 0, vs_seen = 0;
        logic prev = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL pre_reset edge %0d: got %h expected %h", edge_n, got_o, exp_o);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (got_o !== RESET_O) begin
            errors++; $display("FAIL async_reset: got %h expected %h", got_o, RESET_O);
        end
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (got_o !== RESET_O) begin
            errors++; $display("FAIL reset_hold: got %h expected %h", got_o, RESET_O);
        end
        reset_n = 1'b1;
        for (int n = 0; n < HT + 200; n++) begin
            tick();
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                $display("FAIL post_reset edge %0d: got %h expected %h", edge_n, got_o, exp_o);
            end
            if (HSync === 1'b1 && prev !== 1'b1 && first < 0) first = edge_n;
            prev = HSync;
            if (frame === 1'b1) pulses++;
            if (VSync === 1'b1) vs_seen++;
        end
        checks++;
        if (first != 1049) begin
            errors++; $display("FAIL restart_hsync_edge: got %0d expected 1049", first);
        end
        checks++;
        if (pulses != 0 || vs_seen != 0) begin
            errors++; $display("FAIL restart_partial_pulse: got frame=%0d vsync=%0d expected 0", pulses, vs_seen);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            vs_cnt[k] = 0;
            vb_cnt[k] = 0;
        end
        test_reset();
        test_line_timing();
        test_spot_and_shadow();
        test_edges_and_wall();
        test_frame_timing();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/odyssey_video_gen.md
ODYSSEY_VIDEO_GEN -- requirements
Module: odyssey_video_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 1024, active clocks per line.
- H_FRONT, 24, front porch clocks.
- H_SYNC, 94, HSync width in clocks.
- H_BACK, 128, back porch clocks (line total 1270 clocks).
- V_ACTIVE, 240, active lines.
- V_FRONT, 3, front porch lines.
- V_SYNC, 3, VSync width in lines.
- V_BACK, 16, back porch lines (frame total 262 lines).
- SPOT_W, 4, spot width in x units (1 unit = 4 clocks).
- SPOT_H, 8, spot height in lines.
- WALL_X, 128, wall x unit, 1 unit wide.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  system clock, 20 MHz.
- reset_n  in  1  reset, asynchronous, active-low.
- p1_x, p1_y, p2_x, p2_y, ball_x, ball_y  in  8 each  object top-left position (x in units, y in lines).
- wall_en  in  1  draw wall.
- HSync  out  1  horizontal sync, active high.
- VSync  out  1  vertical sync, active high.
- HBlank  out  1  horizontal blanking.
- VBlank  out  1  vertical blanking.
- video  out  8  luma.
- frame  out  1  one-clock pulse at vertical blank start.
REQ-003 Clock is clk; reset is asynchronous and active-low.

Function
REQ-004 The 11-bit h counter SHALL count 0..1269 and wrap to 0. The 9-bit v counter SHALL increment on each h wrap, count 0..261, and wrap to 0.
REQ-005 Horizontal regions SHALL be: active 0..1023, front porch 1024..1047, sync 1048..1141, back porch 1142..1269.
REQ-006 Vertical regions SHALL be: active 0..239, front porch 240..242, sync 243..245, back porch 246..261.
REQ-007 All outputs SHALL be registered and SHALL reflect the counter state of the previous cycle. Latency is exactly 1 clock, with all outputs aligned.
REQ-008 HSync SHALL be 1 while h is in 1048..1141. VSync SHALL be 1 while v is in 243..245, for whole lines.
REQ-009 HBlank SHALL be 1 while h >= 1024. VBlank SHALL be 1 while v >= 240.
REQ-010 Shadow position registers SHALL capture all six position inputs and wall_en on the edge where the counters go from (1269,239) to (0,240). The value present before that edge is the one taken. There SHALL be no other update.
REQ-011 frame SHALL be 1 for exactly one clock per frame, for counter state (0,240).
REQ-012 Object hit: with u = h[9:2], the object is hit when 0 <= u - X < SPOT_W and 0 <= v - Y < SPOT_H.
- Both comparisons SHALL use 9-bit unsigned differences, with no wrap-around.
- Spots at the right or bottom edge SHALL be clipped, never wrapped.
- Y >= 240 SHALL be invisible.
REQ-013 Wall hit SHALL be u == WALL_X with wall_en shadow = 1, on all active lines.
REQ-014 video in the active region SHALL be:
- 8'hFF if any spot is hit;
- else 8'hC0 if the wall is hit;
- else 8'h00.
REQ-015 video SHALL be 8'h00 whenever HBlank or VBlank is asserted.

Reset
REQ-016 While reset_n = 0, outputs SHALL immediately hold these values:
- h = 0, v = 0;
- shadow registers 0;
- HSync = 0, VSync = 0, frame = 0, video = 0;
- HBlank = 1, VBlank = 1.
REQ-017 After release, counting SHALL start from (0,0). Reset asserted mid-line or mid-frame SHALL abandon the frame, with no partial pulses after release.

Verification
REQ-018 Release reset, run 1 line -> HSync first 1 after the 1049th rising edge, 94 clocks wide, period 1270. HBlank high for 246 clocks per line.
REQ-019 Run 2 frames -> frame pulse period 332740 clocks. VSync high for 3810 clocks per frame. VBlank high for 22 lines.
REQ-020 Set p1 = (10,20) before vblank, all others off-screen (y = 250) -> video = FF for h 40..55 on lines 20..27 only, 00 elsewhere.
REQ-021 Change p1_x from 10 to 100 at line 100 -> current frame is unchanged; the next frame shows the spot at h 400..415.
REQ-022 Set ball = (254,236) -> FF only at h 1016..1023 on lines 236..239. Nothing at h 0..7 and nothing on lines 0..3.
REQ-023 wall_en = 1 with p2 at x = 127 -> h 508..523 are FF on p2 lines. Wall h 512..515 reads C0 on other active lines. Assert reset_n = 0 mid-line -> outputs take reset values without waiting for a clock edge.
